// File: rtl/uart_rx_16x_if.sv
// Receiver-side bundle for uart_rx_16x: serial line in, byte/status out.
// slave is the receiver's view; master is the line driver / byte consumer.
interface uart_rx_16x_if;
  logic       rx;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       busy_o;

  modport master (
    output rx,
    input  data_o,
    input  valid_o,
    input  frame_err_o,
    input  busy_o
  );

  modport slave (
    input  rx,
    output data_o,
    output valid_o,
    output frame_err_o,
    output busy_o
  );
endinterface

// File: rtl/uart_rx_16x.sv
// 8N1 UART receiver, LSB first, 16x oversampled from a free-running clk divider.
// Emits a one-cycle valid per good frame or a one-cycle frame error per bad stop bit.
module uart_rx_16x #(
  parameter int unsigned DIV   = 27,
  parameter int unsigned DIV_W = 5
) (
  input logic          clk,
  input logic          rst_n,
  uart_rx_16x_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       sync_q;
  logic [3:0]       sample_q, sample_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             busy_q;
  logic             tick;
  logic             rx_s;

  assign tick  = (div_q == DIV_W'(DIV - 1));
  assign div_d = tick ? '0 : div_q + DIV_W'(1);
  assign rx_s  = sync_q[1];

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_d  = StStart;
            sample_d = 4'd0;
          end
        end
        StStart: begin
          sample_d = sample_q + 4'd1;
          // Mid start bit: confirm the line is still low, else it was a glitch.
          if (sample_q == 4'd7) begin
            if (!rx_s) begin
              state_d  = StData;
              sample_d = 4'd0;
              bit_d    = 3'd0;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StData: begin
          sample_d = sample_q + 4'd1;
          if (sample_q == 4'd15) begin
            shift_d = {rx_s, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = StStop;
          end
        end
        StStop: begin
          sample_d = sample_q + 4'd1;
          if (sample_q == 4'd15) begin
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = StIdle;
            end else begin
              ferr_d  = 1'b1;
              state_d = StBreak;
            end
          end
        end
        StBreak: begin
          // Wait for the line to return high so a held break never starts a frame.
          if (rx_s) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      div_q    <= '0;
      sync_q   <= 2'b11;
      sample_q <= 4'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      sync_q   <= {sync_q[0], bus.rx};
      sample_q <= sample_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      busy_q   <= (state_d != StIdle);
    end
  end

  assign bus.data_o      = data_q;
  assign bus.valid_o     = valid_q;
  assign bus.frame_err_o = ferr_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_16x.sv
// Directed bench for uart_rx_16x: frames are queued as expectations when sent and
// checked by a monitor whenever the receiver pulses valid or frame error.
module tb_uart_rx_16x;
  localparam int unsigned DIV = 27;
  localparam int BIT = 16 * DIV;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  uart_rx_16x_if bus ();

  uart_rx_16x #(.DIV(DIV), .DIV_W(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_pulses = 0;
  int         n_expected = 0;
  logic [7:0] last_good = 8'h00;
  logic       prev_pulse = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int clks);
    bus.rx = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int bclks, input logic stop, input logic push);
    exp_t e;
    if (push) begin
      e.err  = !stop;
      e.data = b;
      sb.push_back(e);
      n_expected++;
    end
    drive(1'b0, bclks);
    for (int i = 0; i < 8; i++) drive(b[i], bclks);
    drive(stop, bclks);
  endtask

  // Scoreboard monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (bus.valid_o || bus.frame_err_o)) begin
      n_pulses++;
      chk("pulse_exclusive", 32'(bus.valid_o & bus.frame_err_o), 32'd0);
      chk("pulse_one_cycle", 32'(prev_pulse), 32'd0);
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pulse_is_frame_err", 32'(bus.frame_err_o), 32'(e.err));
        if (e.err) begin
          chk("data_kept_on_err", 32'(bus.data_o), 32'(last_good));
        end else begin
          chk("data_o", 32'(bus.data_o), 32'(e.data));
          last_good = e.data;
        end
      end
    end
    prev_pulse = bus.valid_o | bus.frame_err_o;
  end

  initial begin
    logic [7:0] b5a;
    int         periods[3];
    periods[0] = 419;
    periods[1] = 445;
    periods[2] = BIT;
    b5a = 8'h5A;

    // Reset state
    bus.rx = 1'b1;
    rst_n  = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_data", 32'(bus.data_o), 32'h00);
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_ferr", 32'(bus.frame_err_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    rst_n = 1'b1;
    drive(1'b1, BIT);
    chk("idle_busy", 32'(bus.busy_o), 32'd0);

    // Single frame
    send(8'h55, BIT, 1'b1, 1'b1);
    drive(1'b1, BIT);
    chk("t1_data", 32'(bus.data_o), 32'h55);
    chk("t1_pulses", 32'(n_pulses), 32'd1);

    // Back-to-back frames
    send(8'hA3, BIT, 1'b1, 1'b1);
    send(8'h0F, BIT, 1'b1, 1'b1);
    drive(1'b1, BIT);
    chk("t2_data", 32'(bus.data_o), 32'h0F);
    chk("t2_pulses", 32'(n_pulses), 32'd3);

    // False start: 3 ticks low
    drive(1'b0, 3 * DIV);
    chk("t3_busy_start", 32'(bus.busy_o), 32'd1);
    drive(1'b1, 2 * BIT);
    chk("t3_busy_back", 32'(bus.busy_o), 32'd0);
    chk("t3_pulses", 32'(n_pulses), 32'd3);

    // Framing error followed by a held break
    send(8'h3C, BIT, 1'b0, 1'b1);
    drive(1'b0, 10 * BIT);
    chk("t4_busy_break1", 32'(bus.busy_o), 32'd1);
    drive(1'b0, 10 * BIT);
    chk("t4_busy_break2", 32'(bus.busy_o), 32'd1);
    chk("t4_data_kept", 32'(bus.data_o), 32'h0F);
    chk("t4_pulses", 32'(n_pulses), 32'd4);
    drive(1'b1, 2 * BIT);
    chk("t4_busy_release", 32'(bus.busy_o), 32'd0);
    send(8'h81, BIT, 1'b1, 1'b1);
    drive(1'b1, BIT);
    chk("t4_data_81", 32'(bus.data_o), 32'h81);

    // Async reset in the middle of bit 4
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(b5a[i], BIT);
    drive(b5a[4], BIT / 2);
    chk("t5_busy_pre", 32'(bus.busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_data", 32'(bus.data_o), 32'h00);
    chk("t5_rst_busy", 32'(bus.busy_o), 32'd0);
    chk("t5_rst_valid", 32'(bus.valid_o), 32'd0);
    chk("t5_rst_ferr", 32'(bus.frame_err_o), 32'd0);
    last_good = 8'h00;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2 * BIT);
    send(8'hFE, BIT, 1'b1, 1'b1);
    drive(1'b1, BIT);
    chk("t5_data_fe", 32'(bus.data_o), 32'hFE);

    // Bit-period sweep, random bytes
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 2; k++) send(8'($urandom_range(0, 255)), periods[p], 1'b1, 1'b1);
      drive(1'b1, BIT);
    end

    drive(1'b1, BIT);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("pulse_count", 32'(n_pulses), 32'(n_expected));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
